// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and defaults for the memory arbiter
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    // Which requester received the most recent grant
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int DEFAULT_TO_W    = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and shared memory bus
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    // Instruction-fetch port
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_ready;
    logic [31:0]     if_rdata;
    logic            if_stall;

    // Data load/store port
    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ready;
    logic [XLEN-1:0] d_rdata;
    logic            d_stall;
    logic            bus_err;

    // Single-port memory bus
    logic            m_req;
    logic            m_we;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic            m_ack;
    logic [XLEN-1:0] m_rdata;

    // Arbiter view: owns the memory bus and the ready/stall responses
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
        output if_ready, if_rdata, if_stall, d_ready, d_rdata, d_stall, bus_err,
        output m_req, m_we, m_addr, m_wdata
    );

    // Environment view: pipeline requesters plus the memory slave
    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
        input  if_ready, if_rdata, if_stall, d_ready, d_rdata, d_stall, bus_err,
        input  m_req, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_arbiter_bus_timer.sv
// rtl/mem_arbiter_bus_timer.sv - watchdog counter flagging an unacknowledged bus access
module bus_timer
    import mem_arb_pkg::*;
#(
    parameter int TO_W    = DEFAULT_TO_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] cnt;

    // Count enabled cycles; clear has priority so the owner can restart per access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The owner clears on expiry, so the counter never wraps past LIMIT
    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter for a single-port memory bus
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = DEFAULT_TO_W
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    arb_state_t      state;
    gnt_t            last_grant;
    logic            m_req_q;
    logic            m_we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic busy_i;
    logic busy_d;
    logic busy;
    logic expired;
    logic done;
    logic grant_d;
    logic if_ready_w;
    logic d_ready_w;

    assign busy_i = (state == ARB_BUSY_I);
    assign busy_d = (state == ARB_BUSY_D);
    assign busy   = busy_i | busy_d;

    // An access ends on ack or on watchdog expiry; ack wins when both coincide
    assign done = busy & (bus.m_ack | expired);

    // Data wins when alone, or on a tie when fetch was granted last
    assign grant_d = bus.d_req & (~bus.if_req | (last_grant == GNT_I));

    bus_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clock),
        .rst_n   (reset),
        .clear   (~busy | done),
        .enable  (busy),
        .expired (expired)
    );

    // Arbiter FSM: grant from IDLE, latch the winner's request, hold it until done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            last_grant <= GNT_I;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state      <= ARB_BUSY_D;
                        last_grant <= GNT_D;
                        m_req_q    <= 1'b1;
                        m_we_q     <= bus.d_we;
                        addr_q     <= bus.d_addr;
                        wdata_q    <= bus.d_wdata;
                    end else if (bus.if_req) begin
                        state      <= ARB_BUSY_I;
                        last_grant <= GNT_I;
                        m_req_q    <= 1'b1;
                        m_we_q     <= 1'b0;
                        addr_q     <= bus.if_addr;
                    end
                end
                ARB_BUSY_I, ARB_BUSY_D: begin
                    if (done) begin
                        state   <= ARB_IDLE;
                        m_req_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;

    // Completion is combinational so the pipeline sees ready in the ack cycle
    assign if_ready_w = busy_i & (bus.m_ack | expired);
    assign d_ready_w  = busy_d & (bus.m_ack | expired);

    assign bus.if_ready = if_ready_w;
    assign bus.d_ready  = d_ready_w;
    assign bus.bus_err  = busy & expired & ~bus.m_ack;

    // Read data is zeroed on an aborted access so a timeout never leaks stale bus data
    assign bus.if_rdata = (busy_i & bus.m_ack) ? bus.m_rdata[31:0] : 32'h0;
    assign bus.d_rdata  = (busy_d & bus.m_ack) ? bus.m_rdata : '0;

    assign bus.if_stall = bus.if_req & ~if_ready_w;
    assign bus.d_stall  = bus.d_req & ~d_ready_w;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory bus between the CPU instruction-fetch port (IF) and the data load/store port (MEM stage).
- One transaction outstanding at a time; round-robin between requesters when both are pending.
- Drives per-port stall signals into the pipeline hazard logic.
- A watchdog aborts any transaction that is never acknowledged, so a dead slave cannot hang the core.

Parameters:
XLEN, 32, data/address width of the data port and memory bus
TIMEOUT, 255, max BUSY cycles without m_ack before abort (1..2^TO_W-1)
TO_W, 8, watchdog counter width

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
if_req  in  1  fetch request; level, held until if_ready
if_addr  in  XLEN  fetch address
if_ready  out  1  fetch complete this cycle
if_rdata  out  32  fetched instruction, valid when if_ready
if_stall  out  1  if_req & ~if_ready
d_req  in  1  data request; level, held until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  XLEN  data address
d_wdata  in  XLEN  store data (already merged by store unit)
d_ready  out  1  data access complete this cycle
d_rdata  out  XLEN  load data, valid when d_ready
d_stall  out  1  d_req & ~d_ready
bus_err  out  1  pulses with if_ready/d_ready when the access timed out
m_req  out  1  memory request, held until m_ack or abort
m_we  out  1  memory write enable
m_addr  out  XLEN  memory address
m_wdata  out  XLEN  memory write data
m_ack  in  1  memory done (read data valid this cycle)
m_rdata  in  XLEN  memory read data

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- State encoding: IDLE, BUSY_I, BUSY_D.
- Reset values:
  - state=IDLE, last_grant=I, watchdog cnt=0.
  - m_req=0, m_we=0, m_addr=0, m_wdata=0.
  - if_ready=0, d_ready=0, bus_err=0.
  - Reset takes effect immediately, even mid-transaction: m_req drops asynchronously and the transaction is lost.
- IDLE:
  - Only if_req: latch if_addr into m_addr, m_we=0, go to BUSY_I.
  - Only d_req: latch d_addr/d_wdata/d_we, go to BUSY_D.
  - Both: grant the port not equal to last_grant, so data wins the first tie after reset. Update last_grant on every grant.
  - Neither: stay in IDLE.
- BUSY_x:
  - m_req=1; m_addr, m_we and m_wdata stay constant for the whole transaction.
  - cnt increments each cycle.
- m_ack=1 in BUSY_x:
  - x_ready=1 combinationally in the same cycle.
  - if_rdata = m_rdata[31:0]; d_rdata = m_rdata (pass-through).
  - Next state is IDLE; cnt clears.
- cnt==TIMEOUT without m_ack:
  - x_ready=1, bus_err=1, rdata=0.
  - m_req drops next cycle; next state is IDLE.
  - If m_ack and timeout coincide, the ack wins (bus_err=0).
- Latency: 2 cycles minimum per access (grant cycle, then ack cycle). A requester that re-asserts req immediately is sampled in the IDLE cycle after ready.
- Requests are not re-sampled while BUSY. Changes to the other port's inputs during BUSY have no effect.
- A request dropped before ready is a protocol violation and is not required to be handled.
- m_ack in IDLE is ignored.
- if_rdata/d_rdata are don't-care when the matching ready is low.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding constants (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D);
  - grant encoding (GNT_I, GNT_D);
  - default TIMEOUT.
- Sub-module bus_timer: TO_W counter with clear/enable inputs and an expired output (cnt==TIMEOUT), reused later by the peripheral bus bridge.
- The arbiter FSM, address/data latches and output muxing stay in mem_arbiter.

Test Plan:
- Reset check: reset=0 mid-BUSY_D with m_req=1 -> m_req=0 immediately, state IDLE, all ready/err=0; after reset=1, if_req@0x100 -> m_req=1 next cycle with m_addr=0x100, m_we=0.
- Single fetch: if_req@0x0, m_ack one cycle after grant with m_rdata=0x00000013 -> if_ready=1 with if_rdata=0x13 that cycle; if_stall high only in the grant cycle.
- Tie arbitration: both req after reset, d_we=1 d_addr=0x2000 d_wdata=0xDEADBEEF -> data granted first (m_we=1, m_wdata=0xDEADBEEF); after d_ready, fetch granted next. Repeated ties alternate D,I,D,I.
- Slow slave: m_ack delayed 5 cycles -> m_addr/m_we/m_wdata stable all 5 cycles, d_stall=1 throughout, d_ready exactly one cycle.
- Timeout: TIMEOUT=4, no m_ack -> after 4 BUSY cycles if_ready=1, bus_err=1, if_rdata=0; m_req low next cycle; a pending d_req is granted afterwards.
- Ack/timeout collision: m_ack on the cycle cnt==TIMEOUT -> ready=1, bus_err=0, rdata=m_rdata.
